// File: rtl/scalar_writeback_arbiter.sv
// Scalar register-file write port: per-source result FIFOs, a round-robin
// arbiter that issues one registered write per cycle, and a pending-register bitmap.
module scalar_writeback_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 36,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*ADDR_W-1:0]    src_addr,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic                       we,
  output logic [ADDR_W-1:0]          write_addr,
  output logic [DATA_W-1:0]          write_data,
  output logic [(2**ADDR_W)-1:0]     pending,
  output logic                       idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Handshake: a source transfers on a rising edge where src_valid & src_ready;
  // src_ready depends only on the registered FIFO count, and a source that sees
  // ready low must hold valid and its payload until it transfers.

  logic [ADDR_W-1:0] mem_addr [N_SRC][DEPTH];
  logic [DATA_W-1:0] mem_data [N_SRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [N_SRC];
  logic [PTR_W-1:0]  rd_ptr   [N_SRC];
  logic [CNT_W-1:0]  count    [N_SRC];

  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [N_SRC-1:0]  not_empty;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  last_grant;

  always_comb begin
    src_ready = '0;
    push      = '0;
    pop       = '0;
    not_empty = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count[i] != CNT_W'(DEPTH));
      push[i]      = src_valid[i] & (count[i] != CNT_W'(DEPTH));
      pop[i]       = grant_valid && (grant_idx == SRC_W'(i));
      not_empty[i] = (count[i] != '0);
    end
  end

  // Search starts one past the last winner and wraps, so each busy source
  // waits at most N_SRC-1 grants.
  always_comb begin : arb_comb
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(last_grant) + k) % N_SRC;
      if (!grant_valid && not_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i]] <= src_addr[i*ADDR_W +: ADDR_W];
        mem_data[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we         <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      last_grant <= SRC_W'(N_SRC - 1);
    end else begin
      we <= grant_valid;
      if (grant_valid) begin
        write_addr <= mem_addr[grant_idx][rd_ptr[grant_idx]];
        write_data <= mem_data[grant_idx][rd_ptr[grant_idx]];
        last_grant <= grant_idx;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin : pending_comb
    logic [PTR_W-1:0] offset;
    offset  = '0;
    pending = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        offset = PTR_W'(j) - rd_ptr[i];
        if (CNT_W'(offset) < count[i]) pending[mem_addr[i][j]] = 1'b1;
      end
    end
    if (we) pending[write_addr] = 1'b1;
  end

  assign idle = ~(|not_empty) & ~we;

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed bench for scalar_writeback_arbiter: per-source drivers, a write
// scoreboard fed from hand-ordered expected writes, and point checks.
module tb_scalar_writeback_arbiter;

  localparam int N_SRC = 3;
  localparam int DW    = 36;
  localparam int AW    = 5;
  localparam int EW    = AW + DW;

  logic               clk;
  logic               rst_n;
  logic [N_SRC-1:0]   src_valid;
  logic [N_SRC-1:0]   src_ready;
  logic [N_SRC*AW-1:0] src_addr;
  logic [N_SRC*DW-1:0] src_data;
  logic               we;
  logic [AW-1:0]      write_addr;
  logic [DW-1:0]      write_data;
  logic [(2**AW)-1:0] pending;
  logic               idle;

  int tests  = 0;
  int failed = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] drv0[$];
  logic [EW-1:0] drv1[$];
  logic [EW-1:0] drv2[$];
  logic [EW-1:0] sb_exp;

  scalar_writeback_arbiter #(
    .N_SRC(N_SRC), .DATA_W(DW), .ADDR_W(AW), .DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .we(we), .write_addr(write_addr), .write_data(write_data),
    .pending(pending), .idle(idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write on the port must match the next expected write
  always @(negedge clk) begin
    if (rst_n && we) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        failed++;
        $error("FAIL sb_extra observed=%0h expected=none", {write_addr, write_data});
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        chk("sb_write", {23'd0, write_addr, write_data}, {23'd0, sb_exp});
      end
    end
  end

  // drivers
  task automatic send(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (s)
      0: drv0.push_back({a, d});
      1: drv1.push_back({a, d});
      default: drv2.push_back({a, d});
    endcase
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic apply();
    logic [EW-1:0] h;
    src_valid = {drv2.size() != 0, drv1.size() != 0, drv0.size() != 0};
    src_addr  = '0;
    src_data  = '0;
    if (drv0.size() != 0) begin h = drv0[0]; src_addr[0*AW +: AW] = h[EW-1:DW]; src_data[0*DW +: DW] = h[DW-1:0]; end
    if (drv1.size() != 0) begin h = drv1[0]; src_addr[1*AW +: AW] = h[EW-1:DW]; src_data[1*DW +: DW] = h[DW-1:0]; end
    if (drv2.size() != 0) begin h = drv2[0]; src_addr[2*AW +: AW] = h[EW-1:DW]; src_data[2*DW +: DW] = h[DW-1:0]; end
  endtask

  // One clock: present heads, take the edge, retire whatever transferred.
  task automatic cycle();
    logic [N_SRC-1:0] x;
    apply();
    x = src_valid & src_ready;
    @(posedge clk);
    #1;
    if (x[0]) void'(drv0.pop_front());
    if (x[1]) void'(drv1.pop_front());
    if (x[2]) void'(drv2.pop_front());
    apply();
  endtask

  initial begin
    rst_n = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    chk("rst_we", we, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_ready", src_ready, 3'b111);
    chk("rst_pending", pending, 0);
    chk("rst_idle", idle, 1);

    // single write, two-cycle latency
    send(0, 5'd5, 36'h123456789);
    expect_wr(5'd5, 36'h123456789);
    cycle();
    chk("single_pend_e0", pending, 32'h20);
    chk("single_we_e0", we, 0);
    chk("single_idle_e0", idle, 0);
    chk("single_ready_e0", src_ready, 3'b111);
    cycle();
    chk("single_we_e1", we, 1);
    chk("single_addr_e1", write_addr, 5);
    chk("single_data_e1", write_data, 36'h123456789);
    chk("single_pend_e1", pending, 32'h20);
    cycle();
    chk("single_we_e2", we, 0);
    chk("single_pend_e2", pending, 0);
    chk("single_idle_e2", idle, 1);
    chk("single_addr_hold", write_addr, 5);

    // asynchronous reset in the middle of a burst
    send(0, 5'd9, 36'hF0);
    send(1, 5'd10, 36'hF1);
    cycle();
    cycle();
    chk("mid_we_before", we, 1);
    chk("mid_addr_before", write_addr, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_waddr", write_addr, 0);
    chk("mid_rst_ready", src_ready, 3'b111);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_idle", idle, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // round robin, two rounds
    send(0, 5'd1, 36'hA1); send(1, 5'd2, 36'hA2); send(2, 5'd3, 36'hA3);
    expect_wr(5'd1, 36'hA1); expect_wr(5'd2, 36'hA2); expect_wr(5'd3, 36'hA3);
    cycle();
    chk("rr_pending", pending, 32'h0E);
    cycle();
    chk("rr1_addr0", write_addr, 1);
    cycle();
    chk("rr1_addr1", write_addr, 2);
    cycle();
    chk("rr1_addr2", write_addr, 3);
    send(0, 5'd1, 36'hB1); send(1, 5'd2, 36'hB2); send(2, 5'd3, 36'hB3);
    expect_wr(5'd1, 36'hB1); expect_wr(5'd2, 36'hB2); expect_wr(5'd3, 36'hB3);
    cycle();
    chk("rr2_we_gap", we, 0);
    cycle();
    chk("rr2_data0", write_data, 36'hB1);
    cycle();
    chk("rr2_data1", write_data, 36'hB2);
    cycle();
    chk("rr2_data2", write_data, 36'hB3);
    cycle();
    chk("rr_idle", idle, 1);

    // backpressure on src1 while src0 keeps arbitration busy
    for (int i = 0; i < 4; i++) send(0, 5'd12, 36'hC0 + 36'(i));
    for (int i = 0; i < 3; i++) send(1, 5'd13, 36'hD0 + 36'(i));
    expect_wr(5'd12, 36'hC0); expect_wr(5'd13, 36'hD0);
    expect_wr(5'd12, 36'hC1); expect_wr(5'd13, 36'hD1);
    expect_wr(5'd12, 36'hC2); expect_wr(5'd13, 36'hD2);
    expect_wr(5'd12, 36'hC3);
    cycle();
    chk("bp_pending", pending, 32'h3000);
    cycle();
    chk("bp_ready_e1", src_ready, 3'b101);
    cycle();
    chk("bp_ready_e2", src_ready, 3'b110);
    chk("bp_data_e2", write_data, 36'hD0);
    cycle();
    chk("bp_ready_e3", src_ready, 3'b101);
    repeat (5) cycle();
    chk("bp_idle", idle, 1);

    // full FIFO popped in the same cycle keeps ready low until the next one
    for (int i = 0; i < 3; i++) send(0, 5'd20, 36'hE0 + 36'(i));
    send(1, 5'd21, 36'hF0);
    expect_wr(5'd21, 36'hF0);
    expect_wr(5'd20, 36'hE0); expect_wr(5'd20, 36'hE1); expect_wr(5'd20, 36'hE2);
    cycle();
    cycle();
    chk("full_ready_low", src_ready, 3'b110);
    cycle();
    chk("full_ready_high", src_ready, 3'b111);
    chk("full_data_e2", write_data, 36'hE0);
    repeat (3) cycle();
    chk("full_idle", idle, 1);

    // two sources writing the same register
    send(0, 5'd7, 36'h70);
    send(2, 5'd7, 36'h72);
    expect_wr(5'd7, 36'h72);
    expect_wr(5'd7, 36'h70);
    cycle();
    chk("ovl_pend_e0", pending, 32'h80);
    cycle();
    chk("ovl_pend_e1", pending, 32'h80);
    chk("ovl_data_e1", write_data, 36'h72);
    cycle();
    chk("ovl_pend_e2", pending, 32'h80);
    chk("ovl_data_e2", write_data, 36'h70);
    cycle();
    chk("ovl_pend_e3", pending, 0);
    chk("ovl_idle", idle, 1);

    cycle();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/scalar_writeback_arbiter.md
Name: scalar_writeback_arbiter

Overview:
- Producer side of the scalar register file write port. Collects results from N_SRC functional units (ALU, multiplier, load unit) over valid/ready channels and buffers each source in its own small FIFO.
- Round-robin arbitration issues at most one registered write per cycle onto we/write_addr/write_data.
- Exports a per-register pending bitmap so the issue stage can hold instructions whose source register has an in-flight write.

Parameters:
- N_SRC, 3, number of result sources.
- DATA_W, 36, register data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- DEPTH, 2, entries per source FIFO (power of two, >=2).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- src_valid  input  N_SRC  per-source result valid.
- src_ready  output  N_SRC  per-source FIFO can accept.
- src_addr  input  N_SRC*ADDR_W  destination register; source i at bits [i*ADDR_W +: ADDR_W].
- src_data  input  N_SRC*DATA_W  result data; source i at bits [i*DATA_W +: DATA_W].
- we  output  1  register-file write enable (registered).
- write_addr  output  ADDR_W  register-file write address (registered).
- write_data  output  DATA_W  register-file write data (registered).
- pending  output  2**ADDR_W  bit r set while any write to register r is buffered or on the output.
- idle  output  1  all FIFOs empty and we low.

Behaviour:
Reset (rst_n low, asynchronous, any time including mid-transfer):
- All FIFOs flushed; we=0, write_addr=0, write_data=0.
- Round-robin pointer set to N_SRC-1, so source 0 has first priority.
- Outputs after reset: src_ready=all 1, pending=0, idle=1.

Accept:
- Source i transfers on a rising edge where src_valid[i] & src_ready[i]; the entry is pushed into FIFO i.
- src_ready[i] = FIFO i not full, derived from registered count only. No combinational path from src_valid or from the current-cycle pop.
- A full FIFO stays not-ready in a cycle where it is popped; ready rises the following cycle.
- src_valid while not ready: no transfer, no state change. The source must hold.

Arbitration (every cycle):
- Candidates = non-empty FIFOs. Search starts at (last_grant+1) mod N_SRC and wraps.
- Winner is popped at the edge. Its addr/data load into write_addr/write_data with we=1, and last_grant = winner.
- No candidates: we=0 at the next edge; write_addr/write_data hold their previous values; pointer unchanged.
- Push and pop of the same FIFO in the same cycle are both legal when not full; count is unchanged.

Latency and ordering:
- Minimum latency: accepted at edge E0 into an empty FIFO with no contention → we=1 for the cycle after edge E1 (2 cycles).
- Sustained throughput is 1 write/cycle total.
- Order is preserved within a source. Across sources, order follows arbitration only; same-register ordering across sources is enforced by the issue stage via pending.
- Fairness: a non-empty source waits at most N_SRC-1 grants.

pending (combinational from registered state):
- Bit r = OR over all valid FIFO entries with addr==r, OR (we & write_addr==r).
- Clears the cycle after the final write to r is presented on we.

idle = (all FIFO counts == 0) & ~we.

FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Test Plan:
- Reset/idle: assert rst_n=0 mid-burst → we=0, write_addr=0, src_ready=3'b111, pending=0, idle=1 immediately, without waiting for a clock.
- Single write: src0 pushes addr=5, data=36'h123456789 at edge E0 → we=1, write_addr=5, write_data=36'h123456789 in the cycle after E1; pending[5]=1 from after E0 through that cycle, then 0.
- Round-robin: all three sources push simultaneously with addrs 1,2,3 → grant order src0,src1,src2 on consecutive cycles. Repeat push → order continues src0,src1,src2 (pointer at 2 after the first round).
- Backpressure: src1 sends 3 back-to-back entries while src0 saturates arbitration → src1_ready drops after 2 accepted. Third entry accepted only after a src1 pop; all three emerge in push order.
- Full push+pop: FIFO0 full and popped this cycle → src_ready[0]=0 this cycle, 1 next cycle; no entry lost or duplicated.
- Pending overlap: src0 addr=7 and src2 addr=7 buffered → pending[7] stays 1 until the second write's we cycle ends, then clears.
